// File: rtl/nexys_input_pkg.sv
// nexys_input_pkg: shared states, button indices and 100 MHz timing defaults for button_conditioner
package nexys_input_pkg;

    typedef enum logic [2:0] {IDLE, QUAL_P, HELD, REPEAT, QUAL_R} btn_state_t;

    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_C = 4;

    localparam int N_BTN_DEF         = 5;
    localparam int CNT_W_DEF         = 26;
    localparam int DEBOUNCE_DEF      = 2_500_000;
    localparam int REPEAT_DELAY_DEF  = 40_000_000;
    localparam int REPEAT_PERIOD_DEF = 5_000_000;

    function automatic bit timing_ok(input int unsigned v, input int w);
        return (v >= 2) && (64'(v) < (64'd1 << w));
    endfunction

endpackage

// File: rtl/btn_channel.sv
// btn_channel: two-flop synchronizer, debounce/auto-repeat FSM and saturating counter for one button
// Auto-repeat (HELD -> REPEAT) exists only when BTN_REPEAT_EN is defined.
module btn_channel
    import nexys_input_pkg::*;
#(
    parameter int CNT_W           = CNT_W_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
)(
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat,
    output logic o_move
);

    localparam logic [CNT_W-1:0] L_DEB = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] L_MAX = '1;
`ifdef BTN_REPEAT_EN
    localparam logic [CNT_W-1:0] L_DLY = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] L_PER = CNT_W'(REPEAT_PERIOD - 1);
`endif

    if (!timing_ok(DEBOUNCE_CYCLES, CNT_W) || !timing_ok(REPEAT_DELAY, CNT_W) ||
        !timing_ok(REPEAT_PERIOD, CNT_W)) begin : g_bad_timing
        $error("btn_channel: timing parameters must be >= 2 and < 2**CNT_W");
    end

    logic [1:0]       r_sync;
    btn_state_t       r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt, w_inc;
    logic             r_level, r_press, r_release, r_repeat, r_move;
    logic             w_level, w_press, w_release, w_repeat;
    logic             w_sync;

    assign w_sync    = r_sync[1];
    assign w_inc     = (r_cnt == L_MAX) ? r_cnt : r_cnt + 1'b1;
    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_repeat  = r_repeat;
    assign o_move    = r_move;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync    <= '0;
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
            r_move    <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_raw};
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_level   <= w_level;
            r_press   <= w_press;
            r_release <= w_release;
            r_repeat  <= w_repeat;
            r_move    <= w_press | w_repeat;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_level   = r_level;
        w_press   = 1'b0;
        w_release = 1'b0;
        w_repeat  = 1'b0;
        case (r_state)
            IDLE: begin
                w_state = w_sync ? QUAL_P : IDLE;
                w_cnt   = w_sync ? CNT_W'(1) : '0;
            end
            QUAL_P: begin
                if (!w_sync) begin
                    w_state = IDLE;
                    w_cnt   = '0;
                end else if (r_cnt == L_DEB) begin
                    w_state = HELD;
                    w_press = 1'b1;
                    w_level = 1'b1;
                    w_cnt   = '0;
                end else
                    w_cnt = w_inc;
            end
            HELD: begin
                if (!w_sync) begin
                    w_state = QUAL_R;
                    w_cnt   = CNT_W'(1);
                end
`ifdef BTN_REPEAT_EN
                else if (r_cnt == L_DLY) begin
                    w_state  = REPEAT;
                    w_repeat = 1'b1;
                    w_cnt    = '0;
                end
`endif
                else
                    w_cnt = w_inc;
            end
            REPEAT: begin
                if (!w_sync) begin
                    w_state = QUAL_R;
                    w_cnt   = CNT_W'(1);
                end
`ifdef BTN_REPEAT_EN
                else if (r_cnt == L_PER) begin
                    w_repeat = 1'b1;
                    w_cnt    = '0;
                end
`endif
                else
                    w_cnt = w_inc;
            end
            QUAL_R: begin
                // a short low glitch returns to HELD and restarts the repeat delay
                if (w_sync) begin
                    w_state = HELD;
                    w_cnt   = '0;
                end else if (r_cnt == L_DEB) begin
                    w_state   = IDLE;
                    w_release = 1'b1;
                    w_level   = 1'b0;
                    w_cnt     = '0;
                end else
                    w_cnt = w_inc;
            end
            default: begin
                w_state = IDLE;
                w_cnt   = '0;
                w_level = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: per-button debounce with level, press/release pulses and auto-repeat move pulses
// Auto-repeat is built only when BTN_REPEAT_EN is defined; otherwise btn_repeat is 0 and btn_move equals btn_press.
module button_conditioner
    import nexys_input_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEF,
    parameter int CNT_W           = CNT_W_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat,
    output logic [N_BTN-1:0] btn_move
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .CNT_W          (CNT_W),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .i_raw    (btn_raw[i]),
            .o_level  (btn_level[i]),
            .o_press  (btn_press[i]),
            .o_release(btn_release[i]),
            .o_repeat (btn_repeat[i]),
            .o_move   (btn_move[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: event scoreboard for button_conditioner (expects repeats only when BTN_REPEAT_EN is defined)
module tb_button_conditioner;
    import nexys_input_pkg::*;

    localparam int NB = 5;
    localparam int D  = 8;
    localparam int RD = 20;
    localparam int RP = 5;
`ifdef BTN_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat, btn_move;
    logic [NB-1:0] exp_level = '0;
    int            t = 0;
    int            n_chk = 0;
    int            n_err = 0;
    longint        q[$];
    int            tb0, tb1;

    button_conditioner #(
        .N_BTN          (NB),
        .CNT_W          (8),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat),
        .btn_move   (btn_move)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, t, got, exp);
        end
    endtask

    // kind: 0 press, 1 repeat, 2 release; key sorts by cycle then channel
    function automatic void push(input int cyc, input int ch, input int kind);
        q.push_back(longint'(cyc) * 32 + longint'(ch * 4 + kind));
    endfunction

    function automatic void push_reps(input int ch, input int first, input int last);
        if (REP_EN)
            for (int c = first; c <= last; c += RP) push(c, ch, 1);
    endfunction

    task automatic monitor();
        logic [NB-1:0] ep, er, el;
        ep = '0;
        er = '0;
        el = '0;
        q.sort();
        while (q.size() != 0 && q[0] / 32 == longint'(t)) begin
            longint e;
            int ch, k;
            e  = q.pop_front();
            ch = int'((e / 4) % 8);
            k  = int'(e % 4);
            if (k == 0) ep[ch] = 1'b1;
            else if (k == 1) er[ch] = 1'b1;
            else el[ch] = 1'b1;
        end
        exp_level = rst ? '0 : (exp_level | ep) & ~el;
        check("press", 32'(btn_press), 32'(ep));
        check("repeat", 32'(btn_repeat), 32'(er));
        check("release", 32'(btn_release), 32'(el));
        check("move", 32'(btn_move), 32'(ep | er));
        check("level", 32'(btn_level), 32'(exp_level));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            t++;
            monitor();
        end
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        step(3);

        // clean press held 60 cycles, then clean release
        tb0 = t;
        push(tb0 + D + 3, BTN_U, 0);
        push_reps(BTN_U, tb0 + D + 3 + RD, tb0 + 62);
        push(tb0 + 60 + D + 3, BTN_U, 2);
        btn_raw[BTN_U] = 1'b1;
        step(60);
        btn_raw[BTN_U] = 1'b0;
        step(20);

        // bounce: toggle every 3 cycles for 30 cycles
        for (int i = 0; i < 10; i++) begin
            btn_raw[BTN_L] = (i % 2 == 0);
            step(3);
        end
        btn_raw[BTN_L] = 1'b0;
        step(20);

        // boundary: D high samples is one short of a press, D+1 is accepted
        btn_raw[BTN_D] = 1'b1;
        step(D);
        btn_raw[BTN_D] = 1'b0;
        step(20);
        tb0 = t;
        push(tb0 + D + 3, BTN_D, 0);
        push(tb0 + D + 1 + D + 3, BTN_D, 2);
        btn_raw[BTN_D] = 1'b1;
        step(D + 1);
        btn_raw[BTN_D] = 1'b0;
        step(20);

        // simultaneous press on U and R, then a 4-cycle release glitch on R
        tb0 = t;
        push(tb0 + D + 3, BTN_U, 0);
        push(tb0 + D + 3, BTN_R, 0);
        push_reps(BTN_U, tb0 + D + 3 + RD, tb0 + 42);
        push(tb0 + 40 + D + 3, BTN_U, 2);
        push_reps(BTN_R, tb0 + 32 + RD, tb0 + 72);
        push(tb0 + 70 + D + 3, BTN_R, 2);
        btn_raw[BTN_U] = 1'b1;
        btn_raw[BTN_R] = 1'b1;
        step(25);
        btn_raw[BTN_R] = 1'b0;
        step(4);
        btn_raw[BTN_R] = 1'b1;
        step(11);
        btn_raw[BTN_U] = 1'b0;
        step(30);
        btn_raw[BTN_R] = 1'b0;
        step(25);

        // reset while repeating with the button still held
        tb0 = t;
        push(tb0 + D + 3, BTN_C, 0);
        push_reps(BTN_C, tb0 + D + 3 + RD, tb0 + 43);
        btn_raw[BTN_C] = 1'b1;
        step(43);
        rst = 1'b1;
        #1;
        check("rst_async", 32'({btn_level, btn_press, btn_release, btn_repeat, btn_move}), 32'd0);
        step(3);
        rst = 1'b0;
        tb1 = t;
        push(tb1 + D + 3, BTN_C, 0);
        push_reps(BTN_C, tb1 + D + 3 + RD, tb1 + 46);
        step(44);
        push(t + D + 3, BTN_C, 2);
        btn_raw[BTN_C] = 1'b0;
        step(20);

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
